aes_launch_ctrl: RTL and testbench
==================================

// Module: aes_launch_ctrl
// PURPOSE
// - Sequencer between the USB register file and the aes core.
// - A rising edge on the host "go" bit:
//   - snapshots key and plaintext;
//   - raises a scope trigger and waits a programmable holdoff;
//   - starts the core and measures its run time in cycles;
//   - latches the ciphertext, then reports done or timeout back to the register file.
// PARAMETERS
// - DATA_W        128   width of key, plaintext and ciphertext
// - HOLDOFF       4     cycles scope_trig leads core_start (0 is legal)
// - CNT_W         16    width of cycle_count
// - TIMEOUT       1000  RUN cycles before abort; must be < 2**CNT_W
// PORTS
// - clk           in   1       system clock (main_clk)
// - reset         in   1       synchronous, active-high
// - go            in   1       host start bit, level; rising edge launches
// - key_in        in   DATA_W  key from register file
// - pt_in         in   DATA_W  plaintext from register file
// - core_key      out  DATA_W  registered key snapshot to aes core
// - core_pt       out  DATA_W  registered plaintext snapshot to aes core
// - core_start    out  1       aes trigger, level, high only in RUN
// - core_done     in   1       aes done
// - core_ct       in   DATA_W  aes ciphertext
// - ct_out        out  DATA_W  latched ciphertext to register file
// - done          out  1       result valid (normal or timeout)
// - busy          out  1       high in ARM or RUN
// - timeout       out  1       last run aborted
// - scope_trig    out  1       to tio_trigger; high from launch to end of RUN
// - cycle_count   out  CNT_W   RUN cycles of last/current run
// BEHAVIOUR
// - Reset values:
//   - all outputs 0; state IDLE; holdoff counter 0.
//   - go_q resets to 1, so a go already high at reset does not launch.
// - go_q <= go every cycle. Edge = go & ~go_q. Edges in ARM/RUN are dropped, not queued.
// - IDLE, edge seen:
//   - core_key <= key_in, core_pt <= pt_in;
//   - done, timeout, cycle_count <= 0; scope_trig <= 1; hcnt <= HOLDOFF;
//   - go to ARM.
// - ARM:
//   - hcnt != 0: hcnt <= hcnt-1.
//   - hcnt == 0: core_start <= 1, go to RUN.
//   - Net effect: core_start rises HOLDOFF+1 cycles after scope_trig.
// - RUN: cycle_count <= cycle_count+1 each cycle.
// - RUN exit, normal:
//   - Trigger: core_done=1 and cycle_count >= 1. A stale done in the first RUN cycle is ignored.
//   - Actions: ct_out <= core_ct, done <= 1; core_start and scope_trig <= 0; go to IDLE.
//   - cycle_count keeps its final value.
// - RUN exit, timeout:
//   - Trigger: cycle_count == TIMEOUT-1 and no qualified core_done.
//   - Actions: timeout <= 1, done <= 1; ct_out unchanged; core_start and scope_trig <= 0; go to IDLE.
//   - Qualified core_done on the same cycle wins: normal completion.
// - core_start low for >= 1 cycle between runs, so core sees a fresh trigger.
// - Inputs key_in/pt_in may change during ARM/RUN. The core sees only the snapshot.
// - Reset mid-run:
//   - outputs 0 on the next cycle; no partial ct_out retained.
//   - core_start dropping resets the core's run.
// - cycle_count never wraps: bounded by TIMEOUT.
// STRUCTURE
// - Package aes_ctrl_pkg:
//   - state enum {IDLE, ARM, RUN}
//   - DATA_W_DEFAULT, CNT_W_DEFAULT
// - One sub-module: rise_detect (go_q register + edge output, reset value parameter).
// - Everything else inline. Top wiring:
//   - go = memory_input bit at 0x440
//   - done to 0x050, ct_out to 0x200
//   - cycle_count to a spare output address
// TESTING
// - Nominal:
//   - Stimulus: core model asserts done 11 cycles after start; key 000102..0f, pt 00112233..eeff; go 0->1.
//   - Response: scope_trig at edge+1; core_start 5 cycles later;
//     ct_out = 69c4e0d86a7b0430d8cdb78070b4c55a; done=1; cycle_count=11.
// - Holdoff edge:
//   - Stimulus: HOLDOFF=0.
//   - Response: core_start exactly 1 cycle after scope_trig.
// - Timeout:
//   - Stimulus: TIMEOUT=20, core never done.
//   - Response: timeout=1, done=1, ct_out unchanged, cycle_count=20, busy=0.
// - Retrigger ignored:
//   - Stimulus: go pulsed low/high during RUN; go held high after done.
//   - Response: exactly one run; no relaunch until go falls and rises.
// - Stale done, snapshot:
//   - Stimulus: core_done=1 on first RUN cycle; key_in changed in ARM.
//   - Response: done ignored; core_key holds original key.
// - Reset mid-RUN:
//   - Stimulus: reset in RUN; go still high after reset.
//   - Response: all outputs 0 next cycle; no launch until a fresh rising edge.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES launch sequencer.
// State encoding, default widths and a small width helper.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int DATA_W_DEFAULT  = 128;
    localparam int CNT_W_DEFAULT   = 16;
    localparam int HOLDOFF_DEFAULT = 4;
    localparam int TIMEOUT_DEFAULT = 1000;

    // Bits needed to hold max_val, never less than one.
    function automatic int width_for(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/aes_launch_ctrl_rise_detect.sv
// Rising-edge detector for a level input.
// Reset value of the delayed copy is a parameter.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    // One-cycle delayed copy of the input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sig_q <= RESET_VAL;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/aes_launch_ctrl.sv
// Sequencer between the host register file and the AES core.
// go edge -> snapshot, scope trigger, holdoff, run, result or timeout.
module aes_launch_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int HOLDOFF = HOLDOFF_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [DATA_W-1:0] key_in,
    input  logic [DATA_W-1:0] pt_in,
    output logic [DATA_W-1:0] core_key,
    output logic [DATA_W-1:0] core_pt,
    output logic              core_start,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_ct,
    output logic [DATA_W-1:0] ct_out,
    output logic              done,
    output logic              busy,
    output logic              timeout,
    output logic              scope_trig,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int HCNT_W = width_for(HOLDOFF);

    state_e r_state;
    state_e w_state_nxt;

    logic [HCNT_W-1:0] r_hcnt;
    logic [HCNT_W-1:0] w_hcnt_nxt;

    logic [DATA_W-1:0] r_core_key, w_core_key_nxt;
    logic [DATA_W-1:0] r_core_pt,  w_core_pt_nxt;
    logic [DATA_W-1:0] r_ct_out,   w_ct_out_nxt;
    logic              r_start,    w_start_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_timeout,  w_timeout_nxt;
    logic              r_scope,    w_scope_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;

    logic w_edge;
    logic w_done_ok;
    logic w_expire;

    // go_q resets high so a go already asserted at reset cannot launch
    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_go_edge (
        .i_clk   (clk),
        .i_reset (reset),
        .i_sig   (go),
        .o_rise  (w_edge)
    );

    // A done in the first RUN cycle is stale from the previous run
    assign w_done_ok = core_done && (r_cnt != '0);
    assign w_expire  = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; edges outside IDLE are simply dropped
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_edge) w_state_nxt = ARM;
            ARM:  if (r_hcnt == '0) w_state_nxt = RUN;
            RUN:  if (w_done_ok || w_expire) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and holdoff counter
    always_comb begin
        w_hcnt_nxt     = r_hcnt;
        w_core_key_nxt = r_core_key;
        w_core_pt_nxt  = r_core_pt;
        w_ct_out_nxt   = r_ct_out;
        w_start_nxt    = r_start;
        w_done_nxt     = r_done;
        w_timeout_nxt  = r_timeout;
        w_scope_nxt    = r_scope;
        w_cnt_nxt      = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_edge) begin
                    w_core_key_nxt = key_in;
                    w_core_pt_nxt  = pt_in;
                    w_done_nxt     = 1'b0;
                    w_timeout_nxt  = 1'b0;
                    w_cnt_nxt      = '0;
                    w_scope_nxt    = 1'b1;
                    w_hcnt_nxt     = HCNT_W'(HOLDOFF);
                end
            end
            ARM: begin
                if (r_hcnt != '0) begin
                    w_hcnt_nxt = r_hcnt - HCNT_W'(1);
                end else begin
                    w_start_nxt = 1'b1;
                end
            end
            RUN: begin
                // Exit cycle still counts, so count ends at TIMEOUT
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_done_ok) begin
                    w_ct_out_nxt = core_ct;
                    w_done_nxt   = 1'b1;
                    w_start_nxt  = 1'b0;
                    w_scope_nxt  = 1'b0;
                end else if (w_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_start_nxt   = 1'b0;
                    w_scope_nxt   = 1'b0;
                end
            end
            default: begin
                w_start_nxt = 1'b0;
                w_scope_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset drops core_start to abort the core
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hcnt     <= '0;
            r_core_key <= '0;
            r_core_pt  <= '0;
            r_ct_out   <= '0;
            r_start    <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_scope    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_hcnt     <= w_hcnt_nxt;
            r_core_key <= w_core_key_nxt;
            r_core_pt  <= w_core_pt_nxt;
            r_ct_out   <= w_ct_out_nxt;
            r_start    <= w_start_nxt;
            r_done     <= w_done_nxt;
            r_timeout  <= w_timeout_nxt;
            r_scope    <= w_scope_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign core_key    = r_core_key;
    assign core_pt     = r_core_pt;
    assign core_start  = r_start;
    assign ct_out      = r_ct_out;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign scope_trig  = r_scope;
    assign cycle_count = r_cnt;
    assign busy        = (r_state == ARM) || (r_state == RUN);

endmodule

// File: tb/tb_aes_launch_ctrl.sv
// Directed bench for aes_launch_ctrl.
// Instance a: HOLDOFF=4, TIMEOUT=20. Instance b: HOLDOFF=0.
module tb_aes_launch_ctrl;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'hffeeddccbbaa99887766554433221100;

    logic clk = 1'b0;
    logic reset;

    logic         a_go, a_core_done, a_core_start;
    logic         a_done, a_busy, a_timeout, a_scope;
    logic [127:0] a_key_in, a_pt_in, a_core_key, a_core_pt;
    logic [127:0] a_core_ct, a_ct_out;
    logic [15:0]  a_cnt;

    logic         b_go, b_core_done, b_core_start;
    logic         b_done, b_busy, b_timeout, b_scope;
    logic [127:0] b_core_key, b_core_pt, b_ct_out;
    logic [15:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_launch_ctrl #(
        .DATA_W (128), .HOLDOFF (4), .CNT_W (16), .TIMEOUT (20)
    ) u_dut_a (
        .clk (clk), .reset (reset), .go (a_go),
        .key_in (a_key_in), .pt_in (a_pt_in),
        .core_key (a_core_key), .core_pt (a_core_pt),
        .core_start (a_core_start), .core_done (a_core_done),
        .core_ct (a_core_ct), .ct_out (a_ct_out),
        .done (a_done), .busy (a_busy), .timeout (a_timeout),
        .scope_trig (a_scope), .cycle_count (a_cnt)
    );

    aes_launch_ctrl #(
        .DATA_W (128), .HOLDOFF (0), .CNT_W (16), .TIMEOUT (20)
    ) u_dut_b (
        .clk (clk), .reset (reset), .go (b_go),
        .key_in (KEY0), .pt_in (PT0),
        .core_key (b_core_key), .core_pt (b_core_pt),
        .core_start (b_core_start), .core_done (b_core_done),
        .core_ct (CT0), .ct_out (b_ct_out),
        .done (b_done), .busy (b_busy), .timeout (b_timeout),
        .scope_trig (b_scope), .cycle_count (b_cnt)
    );

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        a_go        = 1'b1;
        a_key_in    = KEY0;
        a_pt_in     = PT0;
        a_core_done = 1'b0;
        a_core_ct   = '0;
        b_go        = 1'b0;
        b_core_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state, go held high through reset
        check("rst_done",  128'(a_done), 128'd0);
        check("rst_busy",  128'(a_busy), 128'd0);
        check("rst_scope", 128'(a_scope), 128'd0);
        check("rst_start", 128'(a_core_start), 128'd0);
        check("rst_to",    128'(a_timeout), 128'd0);
        check("rst_ct",    a_ct_out, 128'd0);
        check("rst_cnt",   128'(a_cnt), 128'd0);
        repeat (3) tick();
        check("rst_nolaunch", 128'(a_busy), 128'd0);
        a_go = 1'b0;
        tick();

        // Nominal run with retrigger pulses during RUN
        a_go = 1'b1;
        tick();
        check("nom_scope", 128'(a_scope), 128'd1);
        check("nom_busy",  128'(a_busy), 128'd1);
        check("nom_key",   a_core_key, KEY0);
        check("nom_pt",    a_core_pt, PT0);
        repeat (4) tick();
        check("nom_start_early", 128'(a_core_start), 128'd0);
        tick();
        check("nom_start", 128'(a_core_start), 128'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) a_go = 1'b0;
            if (i == 5) a_go = 1'b1;
            tick();
        end
        check("nom_run_busy", 128'(a_busy), 128'd1);
        a_core_done = 1'b1;
        a_core_ct   = CT0;
        tick();
        a_core_done = 1'b0;
        check("nom_done",     128'(a_done), 128'd1);
        check("nom_ct",       a_ct_out, CT0);
        check("nom_cnt",      128'(a_cnt), 128'd11);
        check("nom_to",       128'(a_timeout), 128'd0);
        check("nom_scope_lo", 128'(a_scope), 128'd0);
        check("nom_start_lo", 128'(a_core_start), 128'd0);
        check("nom_idle",     128'(a_busy), 128'd0);
        repeat (4) tick();
        check("retrig_none", 128'(a_busy), 128'd0);

        // Holdoff of zero on instance b
        b_go = 1'b1;
        tick();
        check("h0_scope",    128'(b_scope), 128'd1);
        check("h0_start_lo", 128'(b_core_start), 128'd0);
        tick();
        check("h0_start",    128'(b_core_start), 128'd1);
        repeat (2) tick();
        b_core_done = 1'b1;
        tick();
        b_core_done = 1'b0;
        check("h0_done", 128'(b_done), 128'd1);
        check("h0_cnt",  128'(b_cnt), 128'd3);
        check("h0_ct",   b_ct_out, CT0);

        // Stale done in first RUN cycle, key changed in ARM, then timeout
        a_go = 1'b0;
        tick();
        a_key_in = KEY1;
        a_go     = 1'b1;
        tick();
        check("st_done_clr", 128'(a_done), 128'd0);
        check("st_cnt_clr",  128'(a_cnt), 128'd0);
        a_key_in = KEY2;
        repeat (5) tick();
        check("st_start", 128'(a_core_start), 128'd1);
        a_core_done = 1'b1;
        a_core_ct   = KEY2;
        tick();
        a_core_done = 1'b0;
        check("st_ignored", 128'(a_done), 128'd0);
        check("st_busy",    128'(a_busy), 128'd1);
        check("st_snap",    a_core_key, KEY1);
        repeat (18) tick();
        check("to_early", 128'(a_done), 128'd0);
        tick();
        check("to_flag",  128'(a_timeout), 128'd1);
        check("to_done",  128'(a_done), 128'd1);
        check("to_ct",    a_ct_out, CT0);
        check("to_cnt",   128'(a_cnt), 128'd20);
        check("to_busy",  128'(a_busy), 128'd0);
        check("to_start", 128'(a_core_start), 128'd0);

        // Reset in RUN with go left high
        a_go = 1'b0;
        tick();
        a_go = 1'b1;
        repeat (9) tick();
        check("mr_inrun", 128'(a_core_start), 128'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_start", 128'(a_core_start), 128'd0);
        check("mr_scope", 128'(a_scope), 128'd0);
        check("mr_busy",  128'(a_busy), 128'd0);
        check("mr_cnt",   128'(a_cnt), 128'd0);
        check("mr_ct",    a_ct_out, 128'd0);
        check("mr_key",   a_core_key, 128'd0);
        check("mr_done",  128'(a_done), 128'd0);
        repeat (5) tick();
        check("mr_nolaunch", 128'(a_busy), 128'd0);
        a_go = 1'b0;
        tick();
        a_go = 1'b1;
        tick();
        check("mr_relaunch", 128'(a_scope), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
